sample_packer: RTL and testbench
================================

SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width; only 12 supported, other values SHALL fail elaboration.
REQ-002 Parameter FIFO_DEPTH, default 4: sample FIFO entries, power of two, minimum 2.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 data_in  input  DATA_WIDTH  sample from the upstream stage.
REQ-006 datavalid_in  input  1  data_in valid this cycle; no backpressure is offered upstream.
REQ-007 flush_in  input  1  single-cycle pulse; completes a pending half-pair with zero padding.
REQ-008 byte_ready_in  input  1  downstream accepts byte_out this cycle.
REQ-009 byte_out  output  8  packed byte, registered.
REQ-010 bytevalid_out  output  1  byte_out valid, registered.
REQ-011 overflow_out  output  1  sticky flag: a sample was dropped.

Function
REQ-012 Packing SHALL map sample pair (A, B) to three bytes in order: A[11:4], {A[3:0], B[11:8]}, B[7:0].
REQ-013 A transfer SHALL occur on any cycle with bytevalid_out=1 and byte_ready_in=1.
REQ-014 While bytevalid_out=1 and byte_ready_in=0, byte_out and bytevalid_out SHALL hold stable.
REQ-015 FIFO write SHALL occur on any cycle with datavalid_in=1 and the FIFO not full, or full with a pop in the same cycle.
REQ-016 Overflow: datavalid_in=1 with the FIFO full and no same-cycle pop SHALL drop the sample; overflow_out SHALL be 1 from the next cycle until reset.
REQ-017 FSM states SHALL be ST_B0, ST_B1, ST_B2; reset state is ST_B0.
REQ-018 ST_B0, output register empty or transferring, FIFO non-empty: pop A, load A[11:4], store A[3:0], go to ST_B1.
REQ-019 ST_B1, output register empty or transferring, FIFO non-empty: pop B, load {A[3:0],B[11:8]}, store B[7:0], go to ST_B2.
REQ-020 ST_B1, FIFO empty, flush_in=1: load {A[3:0],4'h0}, store 8'h00, go to ST_B2.
REQ-021 ST_B1, FIFO empty, flush_in=0: wait in ST_B1 with bytevalid_out=0 after the previous byte transfers.
REQ-022 ST_B2, output register empty or transferring: load stored low byte and go to ST_B0; no pop.
REQ-023 flush_in outside ST_B1, or in ST_B1 with the FIFO non-empty, SHALL be ignored.
REQ-024 Latency: with the FIFO empty, FSM in ST_B0 and byte_ready_in=1, a sample presented in cycle t SHALL appear as byte A[11:4] with bytevalid_out=1 in cycle t+2.
REQ-025 Throughput: with byte_ready_in held high, one byte per cycle SHALL be sustained, so 2 samples per 3 cycles is lossless.
REQ-026 Total buffering SHALL be FIFO_DEPTH samples plus the sample being serialised.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 reset=0 at a rising edge SHALL force byte_out=8'h00, bytevalid_out=0, overflow_out=0, FSM=ST_B0, FIFO empty, stored nibble/byte cleared.
REQ-029 Reset mid-pair or mid-backpressure SHALL discard all buffered samples and the pending byte, with no partial byte after release.
REQ-030 Samples presented while reset=0 SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encodings (ST_B0/ST_B1/ST_B2), the packed byte width (8) and the supported DATA_WIDTH (12).
REQ-032 The FIFO SHALL be a sub-module sample_fifo, parameterised by width and depth, providing full, empty and count.
REQ-033 The FSM and output register SHALL reside in sample_packer.

Verification
REQ-034 Samples 0xABC, 0x123 back-to-back, byte_ready_in=1 -> bytes 0xAB, 0xC1, 0x23 on consecutive cycles; first byte at t+2.
REQ-035 Same pair with byte_ready_in toggling 1,0,0,1,… -> identical byte sequence; byte_out stable during stalls; no loss.
REQ-036 byte_ready_in=0 from reset, 7 consecutive samples 0x001..0x007 -> 0x006 and 0x007 dropped; overflow_out=1 from the cycle after 0x006; releasing ready yields bytes of 0x001..0x005 only, 0x005 half pending in ST_B1.
REQ-037 Single sample 0xFED then flush_in pulse -> bytes 0xFE, 0xD0, 0x00; FSM returns to ST_B0.
REQ-038 reset=0 asserted in ST_B2 with 3 samples queued -> next cycle bytevalid_out=0, overflow_out=0; after release, new pair 0x456, 0x789 -> 0x45, 0x67, 0x89.
REQ-039 Continuous random samples at 2 per 3 cycles for 10,000 cycles, ready=1 -> scoreboard match, overflow_out stays 0.

Source files
------------

// File: rtl/sample_packer_pkg.sv
// Shared definitions for the 12-bit sample to byte packer: FSM state
// encodings, byte width and the single supported sample width.
package sample_packer_pkg;

    localparam int BYTE_W               = 8;
    localparam int SUPPORTED_DATA_WIDTH = 12;

    // Which byte of the 3-byte pair group is produced next
    typedef enum logic [1:0] {
        ST_B0 = 2'd0,
        ST_B1 = 2'd1,
        ST_B2 = 2'd2
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO: head entry is visible on rd_data
// while not empty, so the packer can pop and use it in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sample_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A write into a full FIFO is accepted when the head leaves this cycle
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs pairs of 12-bit samples into three bytes (A[11:4], {A[3:0],B[11:8]},
// B[7:0]) behind a small sample FIFO, with a ready/valid byte output.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  datavalid_in,
    input  logic                  flush_in,
    input  logic                  byte_ready_in,
    output logic [BYTE_W-1:0]     byte_out,
    output logic                  bytevalid_out,
    output logic                  overflow_out
);

    if (DATA_WIDTH != SUPPORTED_DATA_WIDTH) begin : g_width_check
        $error("sample_packer: only DATA_WIDTH = 12 is supported");
    end

    state_e                    state_q, state_d;
    logic [BYTE_W-1:0]         byte_q, byte_d;
    logic                      valid_q, valid_d;
    logic [3:0]                nib_q, nib_d;
    logic [BYTE_W-1:0]         low_q, low_d;
    logic                      overflow_q, overflow_d;
    logic                      pop;
    logic                      can_load;
    logic [DATA_WIDTH-1:0]     fifo_rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (datavalid_in),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // The output register may be reloaded when empty or when its byte leaves now
    assign can_load = !valid_q || byte_ready_in;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        valid_d    = valid_q;
        nib_d      = nib_q;
        low_d      = low_q;
        pop        = 1'b0;
        overflow_d = overflow_q || (datavalid_in && fifo_full && !pop);
        if (can_load) begin
            valid_d = 1'b0;
            unique case (state_q)
                ST_B0: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        byte_d  = fifo_rd_data[11:4];
                        nib_d   = fifo_rd_data[3:0];
                        valid_d = 1'b1;
                        state_d = ST_B1;
                    end
                end
                ST_B1: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        byte_d  = {nib_q, fifo_rd_data[11:8]};
                        low_d   = fifo_rd_data[7:0];
                        valid_d = 1'b1;
                        state_d = ST_B2;
                    end else if (flush_in) begin
                        byte_d  = {nib_q, 4'h0};
                        low_d   = 8'h00;
                        valid_d = 1'b1;
                        state_d = ST_B2;
                    end
                end
                ST_B2: begin
                    byte_d  = low_q;
                    valid_d = 1'b1;
                    state_d = ST_B0;
                end
                default: begin
                    state_d = ST_B0;
                end
            endcase
        end
        // pop is final here; recompute the drop decision with it
        overflow_d = overflow_q || (datavalid_in && fifo_full && !pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_B0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            nib_q      <= '0;
            low_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            nib_q      <= nib_d;
            low_q      <= low_d;
            overflow_q <= overflow_d;
        end
    end

    assign byte_out      = byte_q;
    assign bytevalid_out = valid_q;
    assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed and randomized checks of sample_packer against a byte-stream
// reference built from the pair packing rule.
module tb_sample_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] data_in = '0;
    logic        datavalid_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        byte_ready_in = 1'b0;
    logic [7:0]  byte_out;
    logic        bytevalid_out;
    logic        overflow_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;

    sample_packer #(
        .DATA_WIDTH (12),
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .datavalid_in  (datavalid_in),
        .flush_in      (flush_in),
        .byte_ready_in (byte_ready_in),
        .byte_out      (byte_out),
        .bytevalid_out (bytevalid_out),
        .overflow_out  (overflow_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packing rule: pair (A,B) becomes three bytes
    task automatic push_pair(input logic [11:0] a, input logic [11:0] b);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        exp_q.push_back(8'(ai / 16));
        exp_q.push_back(8'((ai % 16) * 16 + bi / 256));
        exp_q.push_back(8'(bi % 256));
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // One clock cycle: observe current outputs, record transfers, drive inputs, advance
    task automatic cycle(input logic dv, input logic [11:0] d, input logic fl,
                         input logic rdy, input logic rst_n);
        if (prev_stall) begin
            chk("stall_valid", 32'(bytevalid_out), 32'd1);
            chk("stall_byte", 32'(byte_out), 32'(prev_byte));
        end
        if (bytevalid_out && rdy && rst_n) begin
            got_q.push_back(byte_out);
            $display("byte transfer %02h at %0t", byte_out, $time);
        end
        prev_stall    = bytevalid_out && !rdy && rst_n;
        prev_byte     = byte_out;
        reset         = rst_n;
        datavalid_in  = dv;
        data_in       = d;
        flush_in      = fl;
        byte_ready_in = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_valid", 32'(bytevalid_out), 32'd0);
        chk("reset_byte", 32'(byte_out), 32'h00);
        chk("reset_ovf", 32'(overflow_out), 32'd0);
        got_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    initial begin
        logic [11:0] first_s;
        logic        have_first;
        logic [11:0] s;

        // Back-to-back pair, ready high: latency t+2 then consecutive bytes
        do_reset();
        cycle(1'b1, 12'hABC, 1'b0, 1'b1, 1'b1);
        chk("lat_t1_valid", 32'(bytevalid_out), 32'd0);
        cycle(1'b1, 12'h123, 1'b0, 1'b1, 1'b1);
        chk("lat_t2_valid", 32'(bytevalid_out), 32'd1);
        chk("lat_t2_byte", 32'(byte_out), 32'hAB);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        chk("b2b_byte1", 32'(byte_out), 32'hC1);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        chk("b2b_byte2", 32'(byte_out), 32'h23);
        chk("b2b_valid2", 32'(bytevalid_out), 32'd1);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        chk("b2b_idle_valid", 32'(bytevalid_out), 32'd0);

        // Same pair with ready toggling 1,0,0,1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(i < 2, (i == 0) ? 12'hABC : 12'h123, 1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b1);
        end
        push_pair(12'hABC, 12'h123);
        compare_stream("toggle_ready");

        // Ready low from reset, seven samples: the last two overflow
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) chk("ovf_before", 32'(overflow_out), 32'd0);
            if (i == 6) chk("ovf_after", 32'(overflow_out), 32'd1);
            cycle(1'b1, 12'(i + 1), 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 15; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        push_pair(12'h001, 12'h002);
        push_pair(12'h003, 12'h004);
        exp_q.push_back(8'h00);
        compare_stream("overflow_drain");
        chk("ovf_sticky", 32'(overflow_out), 32'd1);
        cycle(1'b0, 12'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h00);
        compare_stream("overflow_flush");

        // Single sample plus flush (an early flush in ST_B0 is ignored)
        do_reset();
        cycle(1'b1, 12'hFED, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 12'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 12'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'h00);
        compare_stream("flush");
        cycle(1'b1, 12'h456, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 12'h789, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        push_pair(12'h456, 12'h789);
        compare_stream("after_flush");

        // Reset in ST_B2 with three samples queued discards everything
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 12'(12'h100 + i), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 12'hEEE, 1'b0, 1'b0, 1'b0);
        chk("midreset_valid", 32'(bytevalid_out), 32'd0);
        chk("midreset_ovf", 32'(overflow_out), 32'd0);
        got_q.delete();
        cycle(1'b1, 12'h456, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 12'h789, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        push_pair(12'h456, 12'h789);
        compare_stream("after_reset");

        // Random samples at two per three cycles, ready high
        do_reset();
        have_first = 1'b0;
        first_s    = '0;
        for (int c = 0; c < 9999; c++) begin
            if (c % 3 != 2) begin
                s = 12'($urandom_range(0, 4095));
                if (have_first) begin
                    push_pair(first_s, s);
                    have_first = 1'b0;
                end else begin
                    first_s    = s;
                    have_first = 1'b1;
                end
                cycle(1'b1, s, 1'b0, 1'b1, 1'b1);
            end else begin
                cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
            end
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
        compare_stream("random");
        chk("random_ovf", 32'(overflow_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
